// File: rtl/fibonacci_stream.sv
// Fibonacci term generator with a valid/ready output stream.
// Seeds, limit and end-of-sequence behaviour (stop in DONE or wrap to seeds)
// are captured on start. One term per accepted transfer, with index and last flag.
module fibonacci_stream #(
    parameter int WIDTH = 14,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_wrap,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] f,
    output logic             f_valid,
    input  logic             f_ready,
    output logic [IDX_W-1:0] f_index,
    output logic             f_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] fn_q;
    logic [WIDTH:0]   fn1_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] lim_q;
    logic             wrap_q;
    logic [WIDTH-1:0] s0_q;
    logic [WIDTH-1:0] s1_q;

    logic [WIDTH:0]   sum_d;
    logic [IDX_W-1:0] idx_d;
    logic             beyond_d;

    // Next term, saturating index and end-of-sequence detection.
    // fn1 only advances while it is <= limit (< 2**WIDTH), so fn1+fn always fits
    // in WIDTH+1 bits and any carry keeps the value above every possible limit.
    always_comb begin
        sum_d    = fn1_q + {1'b0, fn_q};
        idx_d    = (&idx_q) ? idx_q : idx_q + 1'b1;
        beyond_d = (fn1_q > {1'b0, lim_q});
    end

    // Sequencer: load on start (highest priority), abort on stop, advance on transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            fn_q    <= '0;
            fn1_q   <= '0;
            idx_q   <= '0;
            lim_q   <= '0;
            wrap_q  <= 1'b0;
            s0_q    <= '0;
            s1_q    <= '0;
        end else if (start) begin
            fn_q    <= seed0;
            fn1_q   <= {1'b0, seed1};
            idx_q   <= '0;
            lim_q   <= limit;
            wrap_q  <= mode_wrap;
            s0_q    <= seed0;
            s1_q    <= seed1;
            state_q <= (seed0 > limit) ? DONE : RUN;
        end else if (stop && state_q != IDLE) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else if (state_q == RUN && f_ready) begin
            if (!beyond_d) begin
                fn_q  <= fn1_q[WIDTH-1:0];
                fn1_q <= sum_d;
                idx_q <= idx_d;
            end else if (wrap_q) begin
                fn_q  <= s0_q;
                fn1_q <= {1'b0, s1_q};
                idx_q <= '0;
            end else begin
                state_q <= DONE;
            end
        end
    end

    // Output decode straight from the registered state and datapath.
    always_comb begin
        f       = (state_q == RUN) ? fn_q : '0;
        f_valid = (state_q == RUN);
        f_index = idx_q;
        f_last  = (state_q == RUN) && beyond_d;
        busy    = (state_q == RUN);
        done    = (state_q == DONE);
    end

endmodule

// File: tb/tb_fibonacci_stream.sv
// Directed bench for fibonacci_stream: table-driven term sequences plus
// hand-written sequences for wrap, overflow, early DONE, stop and async reset.
module tb_fibonacci_stream;

    logic        clk;
    logic        reset;
    logic        start, stop, mode_wrap, f_ready;
    logic [13:0] seed0, seed1, limit, f;
    logic        f_valid, f_last, busy, done;
    logic [7:0]  f_index;

    logic        start8, stop8, wrap8, ready8;
    logic [7:0]  seed0_8, seed1_8, limit8, f8;
    logic        valid8, last8, busy8, done8;
    logic [7:0]  index8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic ready;
        int   f;
        int   idx;
        logic last;
    } vec_t;

    vec_t tbl[$];
    int   fibExp[9] = '{0, 1, 1, 2, 3, 5, 8, 13, 21};

    fibonacci_stream #(.WIDTH(14), .IDX_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .mode_wrap(mode_wrap), .seed0(seed0), .seed1(seed1), .limit(limit),
        .f(f), .f_valid(f_valid), .f_ready(f_ready), .f_index(f_index),
        .f_last(f_last), .busy(busy), .done(done)
    );

    fibonacci_stream #(.WIDTH(8), .IDX_W(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .stop(stop8),
        .mode_wrap(wrap8), .seed0(seed0_8), .seed1(seed1_8), .limit(limit8),
        .f(f8), .f_valid(valid8), .f_ready(ready8), .f_index(index8),
        .f_last(last8), .busy(busy8), .done(done8)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic checkAll(input string name, input int ef, input int ei, input logic el,
                            input logic ev, input logic eb, input logic ed);
        checkOutput({name, ".f"},       32'(f),       32'(ef));
        checkOutput({name, ".f_index"}, 32'(f_index), 32'(ei));
        checkOutput({name, ".f_last"},  32'(f_last),  32'(el));
        checkOutput({name, ".f_valid"}, 32'(f_valid), 32'(ev));
        checkOutput({name, ".busy"},    32'(busy),    32'(eb));
        checkOutput({name, ".done"},    32'(done),    32'(ed));
    endtask

    task automatic applyStimulus(input int s0, input int s1, input int lim, input logic wrap);
        seed0     = 14'(s0);
        seed1     = 14'(s1);
        limit     = 14'(lim);
        mode_wrap = wrap;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic runTable(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            checkAll($sformatf("%s[%0d]", name, i), tbl[i].f, tbl[i].idx, tbl[i].last,
                     1'b1, 1'b1, 1'b0);
            f_ready = tbl[i].ready;
            tick();
        end
        f_ready = 1'b1;
        checkAll({name, ".end"}, 0, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0; stop = 1'b0; mode_wrap = 1'b0; f_ready = 1'b1;
        seed0 = '0; seed1 = '0; limit = '0;
        start8 = 1'b0; stop8 = 1'b0; wrap8 = 1'b0; ready8 = 1'b1;
        seed0_8 = '0; seed1_8 = '0; limit8 = '0;
        repeat (2) tick();
        checkAll("reset", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        checkAll("idle", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Case 1: plain run, ready held high, stop in DONE.
        tbl.delete();
        for (int i = 0; i < 9; i++) tbl.push_back('{1'b1, fibExp[i], i, (i == 8)});
        applyStimulus(0, 1, 21, 1'b0);
        runTable("run");

        // Backpressure: every term first stalled one cycle, then accepted.
        tbl.delete();
        for (int i = 0; i < 9; i++) begin
            tbl.push_back('{1'b0, fibExp[i], i, (i == 8)});
            tbl.push_back('{1'b1, fibExp[i], i, (i == 8)});
        end
        applyStimulus(0, 1, 21, 1'b0);
        runTable("bp");

        // Wrap mode: after 21 the sequence restarts with no idle cycle.
        f_ready = 1'b1;
        applyStimulus(0, 1, 21, 1'b1);
        repeat (8) tick();
        checkAll("wrap.last", 21, 8, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        checkAll("wrap.first", 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        checkAll("wrap.second", 1, 1, 1'b0, 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkAll("wrap.stop", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // seed0 above limit: straight to DONE, never valid.
        applyStimulus(30, 1, 21, 1'b0);
        checkAll("bigseed", 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("bigseed.valid2", 32'(f_valid), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("done.stop.done", 32'(done), 32'd0);

        // Stop while f=5.
        applyStimulus(0, 1, 21, 1'b0);
        repeat (5) tick();
        checkAll("prestop", 5, 5, 1'b0, 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkAll("stop", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // start and stop together mid-run: start wins with new seeds.
        applyStimulus(0, 1, 21, 1'b0);
        repeat (3) tick();
        stop = 1'b1;
        applyStimulus(4, 2, 100, 1'b0);
        stop = 1'b0;
        checkAll("startstop", 4, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        checkAll("startstop.next", 2, 1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        checkAll("unordered.sum", 6, 2, 1'b0, 1'b1, 1'b1, 1'b0);

        // Overflow on the 8-bit instance: 233 is last, carry keeps 377 out.
        seed0_8 = 8'd0; seed1_8 = 8'd1; limit8 = 8'd255; wrap8 = 1'b0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (!last8 && valid8 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("ovf.f", 32'(f8), 32'd233);
        checkOutput("ovf.index", 32'(index8), 32'd13);
        checkOutput("ovf.last", 32'(last8), 32'd1);
        tick();
        checkOutput("ovf.done", 32'(done8), 32'd1);
        checkOutput("ovf.valid", 32'(valid8), 32'd0);

        // Asynchronous reset between clock edges, then a clean restart.
        applyStimulus(0, 1, 21, 1'b0);
        repeat (4) tick();
        #2;
        reset = 1'b0;
        #1;
        checkAll("asyncrst", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        applyStimulus(7, 3, 100, 1'b0);
        checkAll("restart", 7, 0, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
